// File: rtl/axil_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS byte-writable 32-bit registers, also driven out flat on regs_o.
// Define AXIL_SLAVE_REGS_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
module axil_slave_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int NUM_REGS           = 4
) (
   input  logic                                 ACLK,
   input  logic                                 ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
   input  logic [2:0]                           S_AXI_AWPROT,
   input  logic                                 S_AXI_AWVALID,
   output logic                                 S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
   input  logic                                 S_AXI_WVALID,
   output logic                                 S_AXI_WREADY,
   output logic [1:0]                           S_AXI_BRESP,
   output logic                                 S_AXI_BVALID,
   input  logic                                 S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
   input  logic [2:0]                           S_AXI_ARPROT,
   input  logic                                 S_AXI_ARVALID,
   output logic                                 S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
   output logic [1:0]                           S_AXI_RRESP,
   output logic                                 S_AXI_RVALID,
   input  logic                                 S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] regs_o
);

   localparam int DW     = C_S_AXI_DATA_WIDTH;
   localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
   localparam int STRB_W = DW / 8;
   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLAVE_REGS_SLVERR_EN
   localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
   localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   logic              awready_reg, wready_reg, bvalid_reg;
   logic [1:0]        bresp_reg;
   logic              aw_held_reg, w_held_reg;
   logic              aw_held_next, w_held_next, bvalid_next;
   logic [IDX_W-1:0]  aw_idx_reg;
   logic [DW-1:0]     w_data_reg;
   logic [STRB_W-1:0] w_strb_reg;
   logic [DW-1:0]     regs_reg [NUM_REGS];
   logic [NUM_REGS-1:0] wr_sel;

   r_state_t          r_state_reg;
   logic              arready_reg, rvalid_reg;
   logic [DW-1:0]     rdata_reg;
   logic [1:0]        rresp_reg;
   logic [IDX_W-1:0]  ar_idx;
   logic [DW-1:0]     rd_word;
   logic              rd_hit;

   logic aw_hs, w_hs, b_hs, ar_hs, commit;
   logic unused_ok;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign aw_hs  = S_AXI_AWVALID && awready_reg;
   assign w_hs   = S_AXI_WVALID && wready_reg;
   assign b_hs   = bvalid_reg && S_AXI_BREADY;
   assign commit = aw_held_reg && w_held_reg && !bvalid_reg;
   assign ar_hs  = S_AXI_ARVALID && arready_reg;
   assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         assign wr_sel[gi] = commit && (aw_idx_reg == IDX_W'(gi));
         assign regs_o[DW*gi +: DW] = regs_reg[gi];
      end
   endgenerate

   always_comb begin
      aw_held_next = aw_held_reg;
      w_held_next  = w_held_reg;
      bvalid_next  = bvalid_reg;
      if (aw_hs)  aw_held_next = 1'b1;
      if (w_hs)   w_held_next  = 1'b1;
      if (commit) begin
         aw_held_next = 1'b0;
         w_held_next  = 1'b0;
         bvalid_next  = 1'b1;
      end else if (b_hs) begin
         bvalid_next = 1'b0;
      end
   end

   // Ready is registered so it stays low through reset and rises on the first edge after it.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         awready_reg <= 1'b0;
         wready_reg  <= 1'b0;
         bvalid_reg  <= 1'b0;
         bresp_reg   <= RESP_OKAY;
         aw_held_reg <= 1'b0;
         w_held_reg  <= 1'b0;
         aw_idx_reg  <= '0;
         w_data_reg  <= '0;
         w_strb_reg  <= '0;
      end else begin
         aw_held_reg <= aw_held_next;
         w_held_reg  <= w_held_next;
         bvalid_reg  <= bvalid_next;
         awready_reg <= !aw_held_next && !bvalid_next;
         wready_reg  <= !w_held_next && !bvalid_next;
         if (aw_hs) aw_idx_reg <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
         if (w_hs) begin
            w_data_reg <= S_AXI_WDATA;
            w_strb_reg <= S_AXI_WSTRB;
         end
         if (commit) bresp_reg <= (|wr_sel) ? RESP_OKAY : RESP_UNMAPPED;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int k = 0; k < NUM_REGS; k++) regs_reg[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (wr_sel[k] && w_strb_reg[b]) regs_reg[k][8*b +: 8] <= w_data_reg[8*b +: 8];
            end
         end
      end
   end

   // Unmapped indices match no register, leaving rd_word at zero.
   always_comb begin
      rd_word = '0;
      rd_hit  = 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (ar_idx == IDX_W'(k)) begin
            rd_word = regs_reg[k];
            rd_hit  = 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state_reg <= R_IDLE;
         arready_reg <= 1'b0;
         rvalid_reg  <= 1'b0;
         rdata_reg   <= '0;
         rresp_reg   <= RESP_OKAY;
      end else begin
         case (r_state_reg)
            R_IDLE: begin
               arready_reg <= 1'b1;
               if (ar_hs) begin
                  r_state_reg <= R_DATA;
                  arready_reg <= 1'b0;
                  rvalid_reg  <= 1'b1;
                  rdata_reg   <= rd_word;
                  rresp_reg   <= rd_hit ? RESP_OKAY : RESP_UNMAPPED;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  r_state_reg <= R_IDLE;
                  arready_reg <= 1'b1;
                  rvalid_reg  <= 1'b0;
               end
            end
            default: r_state_reg <= R_IDLE;
         endcase
      end
   end

   assign S_AXI_AWREADY = awready_reg;
   assign S_AXI_WREADY  = wready_reg;
   assign S_AXI_BVALID  = bvalid_reg;
   assign S_AXI_BRESP   = bresp_reg;
   assign S_AXI_ARREADY = arready_reg;
   assign S_AXI_RVALID  = rvalid_reg;
   assign S_AXI_RDATA   = rdata_reg;
   assign S_AXI_RRESP   = rresp_reg;

endmodule

// File: tb/tb_axil_slave_regs.sv
// Self-checking bench for axil_slave_regs: scoreboard queues hold expected responses per transaction.
module tb_axil_slave_regs;

   logic         ACLK = 1'b0;
   logic         ARESETN = 1'b0;
   logic [4:0]   S_AXI_AWADDR = '0;
   logic [2:0]   S_AXI_AWPROT = '0;
   logic         S_AXI_AWVALID = 1'b0;
   logic         S_AXI_AWREADY;
   logic [31:0]  S_AXI_WDATA = '0;
   logic [3:0]   S_AXI_WSTRB = '0;
   logic         S_AXI_WVALID = 1'b0;
   logic         S_AXI_WREADY;
   logic [1:0]   S_AXI_BRESP;
   logic         S_AXI_BVALID;
   logic         S_AXI_BREADY = 1'b0;
   logic [4:0]   S_AXI_ARADDR = '0;
   logic [2:0]   S_AXI_ARPROT = '0;
   logic         S_AXI_ARVALID = 1'b0;
   logic         S_AXI_ARREADY;
   logic [31:0]  S_AXI_RDATA;
   logic [1:0]   S_AXI_RRESP;
   logic         S_AXI_RVALID;
   logic         S_AXI_RREADY = 1'b0;
   logic [127:0] regs_o;

`ifdef AXIL_SLAVE_REGS_SLVERR_EN
   localparam logic [1:0] EXP_UNMAPPED = 2'b10;
`else
   localparam logic [1:0] EXP_UNMAPPED = 2'b00;
`endif

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rd_exp_t;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] model [4];
   logic [1:0]  wr_q [$];
   rd_exp_t     rd_q [$];

   axil_slave_regs #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(5),
      .NUM_REGS(4)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .regs_o(regs_o)
   );

   always #5 ACLK = ~ACLK;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
      return r;
   endfunction

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output bit ok);
      bit aw_done, w_done, aw_fire, w_fire;
      aw_done = 0; w_done = 0; ok = 0; resp = 2'bxx;
      @(posedge ACLK); #1;
      S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
      for (int c = 0; c < 50 && !(aw_done && w_done); c++) begin
         @(negedge ACLK);
         aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
         w_fire  = S_AXI_WVALID && S_AXI_WREADY;
         @(posedge ACLK); #1;
         if (aw_fire) begin S_AXI_AWVALID = 1'b0; aw_done = 1; end
         if (w_fire)  begin S_AXI_WVALID = 1'b0;  w_done = 1;  end
      end
      for (int c = 0; c < 50; c++) begin
         @(negedge ACLK);
         if (S_AXI_BVALID) begin
            resp = S_AXI_BRESP; ok = 1;
            @(posedge ACLK); #1;
            break;
         end
      end
      S_AXI_BREADY = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
   endtask

   task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output bit ok);
      bit ar_done, ar_fire;
      ar_done = 0; ok = 0; data = 'x; resp = 2'bxx;
      @(posedge ACLK); #1;
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
      for (int c = 0; c < 50 && !ar_done; c++) begin
         @(negedge ACLK);
         ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
         @(posedge ACLK); #1;
         if (ar_fire) begin S_AXI_ARVALID = 1'b0; ar_done = 1; end
      end
      for (int c = 0; c < 50; c++) begin
         @(negedge ACLK);
         if (S_AXI_RVALID) begin
            data = S_AXI_RDATA; resp = S_AXI_RRESP; ok = 1;
            @(posedge ACLK); #1;
            break;
         end
      end
      S_AXI_RREADY = 1'b0; S_AXI_ARVALID = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge ACLK);
      #1;
      n_checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0 ||
          regs_o !== 128'h0 || S_AXI_RDATA !== 32'h0 || S_AXI_BRESP !== 2'b00 || S_AXI_RRESP !== 2'b00)
         $display("FAIL reset_state got aw/w/ar/b/r=%b regs=%h required 00000 regs=0",
                  {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}, regs_o);
      else n_pass++;
      @(negedge ACLK); ARESETN = 1'b1;
      @(posedge ACLK); #1;
      n_checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111)
         $display("FAIL ready_after_reset got %b required 111",
                  {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
      else n_pass++;
      for (int i = 0; i < 4; i++) model[i] = 32'h0;
      $display("txn reset released");
   endtask

   task automatic test_basic_rw();
      logic [1:0] resp, exp_r; logic [31:0] data; bit ok; rd_exp_t e;
      for (int i = 0; i < 4; i++) begin
         wr_q.push_back(2'b00);
         model[i] = merge(model[i], 32'(i + 1), 4'hF);
         axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp, ok);
         exp_r = wr_q.pop_front();
         n_checks++;
         if (!ok || resp !== exp_r) $display("FAIL basic_bresp[%0d] got %b ok=%0d required %b", i, resp, ok, exp_r);
         else n_pass++;
         $display("txn write addr=%h data=%h bresp=%b", i * 4, i + 1, resp);
      end
      for (int i = 0; i < 4; i++) begin
         rd_q.push_back('{data: model[i], resp: 2'b00});
         axi_read(5'(i * 4), data, resp, ok);
         e = rd_q.pop_front();
         n_checks++;
         if (!ok || data !== e.data || resp !== e.resp)
            $display("FAIL basic_read[%0d] got %h/%b required %h/%b", i, data, resp, e.data, e.resp);
         else n_pass++;
         $display("txn read addr=%h data=%h rresp=%b", i * 4, data, resp);
      end
      n_checks++;
      if (regs_o !== 128'h00000004_00000003_00000002_00000001)
         $display("FAIL basic_regs_o got %h required 00000004000000030000000200000001", regs_o);
      else n_pass++;
   endtask

   task automatic test_strobe();
      logic [1:0] resp; logic [31:0] data; bit ok; rd_exp_t e;
      axi_write(5'h0, 32'h11223344, 4'hF, resp, ok);
      model[0] = merge(model[0], 32'h11223344, 4'hF);
      axi_write(5'h0, 32'hAABBCCDD, 4'h5, resp, ok);
      model[0] = merge(model[0], 32'hAABBCCDD, 4'h5);
      rd_q.push_back('{data: 32'h11BB33DD, resp: 2'b00});
      axi_read(5'h0, data, resp, ok);
      e = rd_q.pop_front();
      n_checks++;
      if (!ok || data !== e.data || resp !== e.resp)
         $display("FAIL strobe_read got %h/%b required %h/%b", data, resp, e.data, e.resp);
      else n_pass++;
      axi_write(5'h4, 32'hFFFFFFFF, 4'h0, resp, ok);
      rd_q.push_back('{data: model[1], resp: 2'b00});
      axi_read(5'h4, data, resp, ok);
      e = rd_q.pop_front();
      n_checks++;
      if (!ok || data !== e.data) $display("FAIL strobe_zero got %h required %h", data, e.data);
      else n_pass++;
      $display("txn strobe reg0=%h", model[0]);
   endtask

   task automatic test_w_before_aw();
      logic [1:0] resp, exp_r; logic [31:0] data; bit ok, seen; rd_exp_t e;
      wr_q.push_back(2'b00);
      @(posedge ACLK); #1;
      S_AXI_WDATA = 32'hCAFE0001; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
      @(posedge ACLK); #1;
      S_AXI_WVALID = 1'b0;
      repeat (2) @(posedge ACLK);
      #1;
      n_checks++;
      if (S_AXI_WREADY !== 1'b0 || S_AXI_AWREADY !== 1'b1 || S_AXI_BVALID !== 1'b0)
         $display("FAIL w_held got wready=%b awready=%b bvalid=%b required 0 1 0",
                  S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID);
      else n_pass++;
      S_AXI_AWADDR = 5'h8; S_AXI_AWVALID = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge ACLK);
         if (S_AXI_BVALID) seen = 1;
      end
      model[2] = 32'hCAFE0001;
      exp_r = wr_q.pop_front();
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if (!seen || S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== exp_r || S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0)
            $display("FAIL b_hold[%0d] got bvalid=%b bresp=%b aw/wready=%b%b required 1 %b 00",
                     c, S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY, exp_r);
         else n_pass++;
         @(negedge ACLK);
      end
      S_AXI_BREADY = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_BREADY = 1'b0;
      n_checks++;
      if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1)
         $display("FAIL b_release got bvalid=%b aw/wready=%b%b required 0 11",
                  S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
      else n_pass++;
      rd_q.push_back('{data: model[2], resp: 2'b00});
      axi_read(5'h8, data, resp, ok);
      e = rd_q.pop_front();
      n_checks++;
      if (!ok || data !== e.data) $display("FAIL w_first_read got %h required %h", data, e.data);
      else n_pass++;
      $display("txn w-before-aw reg2=%h", data);
   endtask

   task automatic test_read_hold();
      logic [1:0] resp; logic [31:0] data; bit ok; rd_exp_t e;
      rd_q.push_back('{data: model[1], resp: 2'b00});
      @(posedge ACLK); #1;
      S_AXI_AWADDR = 5'h4; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b0;
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      S_AXI_ARADDR = 5'h4; S_AXI_ARVALID = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_ARVALID = 1'b0;
      model[1] = 32'h55;
      e = rd_q.pop_front();
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== e.data || S_AXI_RRESP !== e.resp)
            $display("FAIL r_hold[%0d] got rvalid=%b rdata=%h required 1 %h", c, S_AXI_RVALID, S_AXI_RDATA, e.data);
         else n_pass++;
         @(posedge ACLK); #1;
      end
      S_AXI_RREADY = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
      n_checks++;
      if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1 || S_AXI_BVALID !== 1'b0)
         $display("FAIL r_release got rvalid=%b arready=%b bvalid=%b required 0 1 0",
                  S_AXI_RVALID, S_AXI_ARREADY, S_AXI_BVALID);
      else n_pass++;
      rd_q.push_back('{data: model[1], resp: 2'b00});
      axi_read(5'h4, data, resp, ok);
      e = rd_q.pop_front();
      n_checks++;
      if (!ok || data !== e.data) $display("FAIL r_after_write got %h required %h", data, e.data);
      else n_pass++;
      $display("txn read-hold reg1=%h", data);
   endtask

   task automatic test_unmapped();
      logic [1:0] resp, exp_r; logic [31:0] data; bit ok; rd_exp_t e;
      logic [4:0] addrs [2];
      addrs[0] = 5'h10; addrs[1] = 5'h1C;
      for (int i = 0; i < 2; i++) begin
         wr_q.push_back(EXP_UNMAPPED);
         axi_write(addrs[i], 32'hDEADBEEF, 4'hF, resp, ok);
         exp_r = wr_q.pop_front();
         n_checks++;
         if (!ok || resp !== exp_r) $display("FAIL unmapped_bresp[%0d] got %b required %b", i, resp, exp_r);
         else n_pass++;
         rd_q.push_back('{data: 32'h0, resp: EXP_UNMAPPED});
         axi_read(addrs[i], data, resp, ok);
         e = rd_q.pop_front();
         n_checks++;
         if (!ok || data !== e.data || resp !== e.resp)
            $display("FAIL unmapped_read[%0d] got %h/%b required %h/%b", i, data, resp, e.data, e.resp);
         else n_pass++;
         $display("txn unmapped addr=%h rdata=%h rresp=%b", addrs[i], data, resp);
      end
      n_checks++;
      if (regs_o !== {model[3], model[2], model[1], model[0]})
         $display("FAIL unmapped_regs got %h required %h", regs_o, {model[3], model[2], model[1], model[0]});
      else n_pass++;
   endtask

   task automatic test_async_reset();
      logic [1:0] resp; logic [31:0] data; bit ok, seen; rd_exp_t e;
      @(posedge ACLK); #1;
      S_AXI_AWADDR = 5'h0; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge ACLK);
         if (S_AXI_BVALID) seen = 1;
      end
      #2 ARESETN = 1'b0;
      #1;
      n_checks++;
      if (!seen || S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b0 || regs_o !== 128'h0)
         $display("FAIL async_reset got seen=%0d bvalid=%b awready=%b regs=%h required 1 0 0 0",
                  seen, S_AXI_BVALID, S_AXI_AWREADY, regs_o);
      else n_pass++;
      @(negedge ACLK); ARESETN = 1'b1;
      for (int i = 0; i < 4; i++) model[i] = 32'h0;
      for (int i = 0; i < 4; i++) begin
         rd_q.push_back('{data: model[i], resp: 2'b00});
         axi_read(5'(i * 4), data, resp, ok);
         e = rd_q.pop_front();
         n_checks++;
         if (!ok || data !== e.data || resp !== e.resp)
            $display("FAIL post_reset_read[%0d] got %h/%b required %h/%b", i, data, resp, e.data, e.resp);
         else n_pass++;
      end
      $display("txn async reset mid-write");
   endtask

   initial begin
      test_reset();
      test_basic_rw();
      test_strobe();
      test_w_before_aw();
      test_read_hold();
      test_unmapped();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
